flex_serial_to_parallel_sr: RTL and testbench
=============================================

# flex_serial_to_parallel_sr

Parameterizable serial-to-parallel shift register. It accumulates a 1-bit serial stream into a NUM_BITS-wide parallel word, in a selectable shift direction. In the Sobel output path it packs single-bit edge-pixel results into 32-bit words for the output buffer. A word-complete pulse and a fill counter let the consumer detect full words without an external counter.

## Interface
- NUM_BITS, default 4: parallel word width; legal range 2..64. Design instance uses 32.
- SHIFT_MSB, default 1: 1 means shift toward the MSB (new bit enters at bit 0); 0 means shift toward the LSB (new bit enters at bit NUM_BITS-1).
- clk  input  1  system clock; all state changes on the rising edge.
- n_rst  input  1  reset, asynchronous and active-high (asserted = 1 despite the codebase name).
- shift_enable  input  1  when 1 at a rising edge, capture serial_in and shift by one position.
- serial_in  input  1  serial data bit.
- parallel_out  output  NUM_BITS  current register contents.
- bit_count  output  $clog2(NUM_BITS+1)  number of bits shifted into the current word, 0..NUM_BITS-1.
- word_done  output  1  registered one-cycle pulse; high in the cycle after the shift that completed a word.

## Operation
- Reset (n_rst=1, asynchronous):
  - parallel_out = all ones (idle-line value).
  - bit_count = 0.
  - word_done = 0.
  - Reset holds while asserted; deassertion takes effect at the next clock edge. Reset mid-word discards partial data.
- Shift with SHIFT_MSB=1: parallel_out <= {parallel_out[NUM_BITS-2:0], serial_in}.
- Shift with SHIFT_MSB=0: parallel_out <= {serial_in, parallel_out[NUM_BITS-1:1]}.
- shift_enable=0: parallel_out, bit_count and word_done hold, except word_done, which returns to 0.
- bit_count:
  - Increments on each enabled shift.
  - On the shift that would reach NUM_BITS, it wraps to 0 and word_done is set to 1 for exactly one cycle.
- A word is never cleared on completion. Shifting continues and old bits fall off the far end, so parallel_out always holds the most recent NUM_BITS bits.
- Continuous shifting is supported: word_done pulses every NUM_BITS enabled cycles.
- There is no state machine beyond the wrap counter. All outputs come directly from registers, with no combinational path from inputs to outputs.
- Illegal NUM_BITS (<2) must fail elaboration.

## Timing
- Latency: serial_in sampled at edge k appears in parallel_out bit 0 (SHIFT_MSB=1) or bit NUM_BITS-1 (SHIFT_MSB=0) immediately after edge k.
- The bit shifted at edge k occupies the far end after NUM_BITS-1 further enabled shifts.
- word_done rises after the edge of the NUM_BITS-th enabled shift, coincident with parallel_out holding the completed word, and falls after the next edge.
- shift_enable may toggle every cycle. Gaps do not affect bit_count or data.
- Reset asserted in the same cycle as shift_enable: reset wins.

## Test plan
- Reset: NUM_BITS=32, drive serial_in=0 and shift_enable=1, then assert n_rst asynchronously between edges -> parallel_out=32'hFFFFFFFF, bit_count=0, word_done=0 immediately, without waiting for a clock edge.
- MSB direction: NUM_BITS=4, SHIFT_MSB=1, after reset shift 1,0,1,1 -> parallel_out=4'b1011, word_done pulses for one cycle after the 4th edge, bit_count=0.
- LSB direction: NUM_BITS=4, SHIFT_MSB=0, shift 1,0,1,1 -> parallel_out=4'b1101.
- Hold: NUM_BITS=32, shift in 8'hA5 (MSB first), then 10 cycles with shift_enable=0 -> parallel_out=32'hFFFFFFA5, bit_count=8 and word_done=0 throughout.
- Continuous stream: NUM_BITS=32, 64 consecutive enabled shifts of alternating 1,0 -> word_done high exactly at cycles 33 and 65 (relative to first shift edge=1), parallel_out=32'hAAAAAAAA after each.
- Mid-word reset: 20 shifts, pulse reset, 32 shifts of 0 -> parallel_out=0, a single word_done pulse after the 32nd shift.

Source files
------------

// File: rtl/flex_serial_to_parallel_sr.sv
// Serial-to-parallel shift register with selectable shift direction, a wrap
// counter that tracks word fill and a registered word-complete pulse.
module flex_serial_to_parallel_sr #(
    parameter int NUM_BITS  = 4,
    parameter bit SHIFT_MSB = 1'b1
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            shift_enable,
    input  logic                            serial_in,
    output logic [NUM_BITS-1:0]             parallel_out,
    output logic [$clog2(NUM_BITS+1)-1:0]   bit_count,
    output logic                            word_done
);

    localparam int CW = $clog2(NUM_BITS + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(NUM_BITS - 1);

    generate
        if (NUM_BITS < 2) begin : g_bad_width
            $error("flex_serial_to_parallel_sr: NUM_BITS must be at least 2");
        end
    endgenerate

    logic [NUM_BITS-1:0] r_shift;
    logic [CW-1:0]       r_count;
    logic                r_done;

    logic [NUM_BITS-1:0] w_shifted;
    logic                w_last;

    generate
        if (SHIFT_MSB) begin : g_toward_msb
            assign w_shifted = {r_shift[NUM_BITS-2:0], serial_in};
        end else begin : g_toward_lsb
            assign w_shifted = {serial_in, r_shift[NUM_BITS-1:1]};
        end
    endgenerate

    assign w_last = (r_count == LAST_COUNT);

    // Reset polarity is active-high even though the port is named n_rst;
    // the register resets to all ones, the idle-line value of the stream.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            r_shift <= '1;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in
            // this block based on pre-edge values, regardless of statement order.
            r_done <= 1'b0;
            if (shift_enable) begin
                r_shift <= w_shifted;
                if (w_last) begin
                    r_count <= '0;
                    r_done  <= 1'b1;
                end else begin
                    r_count <= r_count + CW'(1);
                end
            end
        end
    end

    assign parallel_out = r_shift;
    assign bit_count    = r_count;
    assign word_done    = r_done;

endmodule

// File: tb/tb_flex_serial_to_parallel_sr.sv
// Bench for flex_serial_to_parallel_sr: three instances (32/MSB, 4/MSB, 4/LSB)
// share stimulus and are compared against a bit-history reference model.
module tb_flex_serial_to_parallel_sr;

    logic clk;
    logic n_rst;
    logic shift_enable;
    logic serial_in;

    logic [31:0] po32;
    logic [5:0]  bc32;
    logic        wd32;
    logic [3:0]  po4m;
    logic [2:0]  bc4m;
    logic        wd4m;
    logic [3:0]  po4l;
    logic [2:0]  bc4l;
    logic        wd4l;

    int checks = 0;
    int errors = 0;

    flex_serial_to_parallel_sr #(.NUM_BITS(32), .SHIFT_MSB(1'b1)) u_dut32 (
        .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .serial_in(serial_in),
        .parallel_out(po32), .bit_count(bc32), .word_done(wd32)
    );

    flex_serial_to_parallel_sr #(.NUM_BITS(4), .SHIFT_MSB(1'b1)) u_dut4m (
        .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .serial_in(serial_in),
        .parallel_out(po4m), .bit_count(bc4m), .word_done(wd4m)
    );

    flex_serial_to_parallel_sr #(.NUM_BITS(4), .SHIFT_MSB(1'b0)) u_dut4l (
        .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .serial_in(serial_in),
        .parallel_out(po4l), .bit_count(bc4l), .word_done(wd4l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instance views so the random test can loop over all three.
    logic [63:0] act_word [3];
    logic [7:0]  act_cnt  [3];
    logic        act_done [3];
    int          cfg_n    [3] = '{32, 4, 4};
    bit          cfg_msb  [3] = '{1'b1, 1'b1, 1'b0};

    assign act_word[0] = {32'b0, po32};
    assign act_word[1] = {60'b0, po4m};
    assign act_word[2] = {60'b0, po4l};
    assign act_cnt[0]  = {2'b0, bc32};
    assign act_cnt[1]  = {5'b0, bc4m};
    assign act_cnt[2]  = {5'b0, bc4l};
    assign act_done[0] = wd32;
    assign act_done[1] = wd4m;
    assign act_done[2] = wd4l;

    // Reference model: every accepted bit since reset, newest at the back.
    bit hist[$];
    int shifts;
    bit last_en;

    function automatic logic [63:0] exp_word(input int n, input bit msb);
        logic [63:0] w;
        int idx;
        bit b;
        w = '0;
        for (int i = 0; i < n; i++) begin
            idx = hist.size() - 1 - i;
            b = (idx >= 0) ? hist[idx] : 1'b1;
            if (msb) w[i] = b;
            else     w[n-1-i] = b;
        end
        return w;
    endfunction

    function automatic int exp_count(input int n);
        return shifts % n;
    endfunction

    function automatic bit exp_done(input int n);
        return last_en && (shifts > 0) && (shifts % n == 0);
    endfunction

    task automatic model_clear();
        hist.delete();
        shifts  = 0;
        last_en = 1'b0;
    endtask

    task automatic step(input bit en, input bit din);
        @(negedge clk);
        shift_enable = en;
        serial_in    = din;
        @(posedge clk);
        if (!n_rst) begin
            last_en = en;
            if (en) begin
                hist.push_back(din);
                shifts++;
                if (hist.size() > 64) void'(hist.pop_front());
            end
        end else begin
            last_en = 1'b0;
        end
        #1;
    endtask

    task automatic assert_reset();
        @(negedge clk);
        shift_enable = 1'b1;
        serial_in    = 1'b0;
        #2;
        n_rst = 1'b1;
        model_clear();
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        shift_enable = 1'b0;
        n_rst        = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0);
        checks++;
        if (wd32 !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_done got=%b want=1", wd32);
        end
        assert_reset();
        checks++;
        if (po32 !== 32'hFFFF_FFFF || bc32 !== 6'd0 || wd32 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got po=%h bc=%0d wd=%b want po=ffffffff bc=0 wd=0",
                     po32, bc32, wd32);
        end
        checks++;
        if (po4m !== 4'hF || po4l !== 4'hF || bc4m !== 3'd0 || bc4l !== 3'd0) begin
            errors++;
            $display("FAIL async_reset_4 got m=%h l=%h bcm=%0d bcl=%0d want f f 0 0",
                     po4m, po4l, bc4m, bc4l);
        end
        @(posedge clk);
        #1;
        checks++;
        if (po32 !== 32'hFFFF_FFFF || bc32 !== 6'd0) begin
            errors++;
            $display("FAIL reset_wins got po=%h bc=%0d want po=ffffffff bc=0", po32, bc32);
        end
        release_reset();
    endtask

    task automatic test_direction();
        bit pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        assert_reset();
        release_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, pat[i]);
            if (i == 2) begin
                checks++;
                if (wd4m !== 1'b0 || bc4m !== 3'd3) begin
                    errors++;
                    $display("FAIL dir_third got wd=%b bc=%0d want wd=0 bc=3", wd4m, bc4m);
                end
            end
        end
        checks++;
        if (po4m !== 4'b1011) begin
            errors++;
            $display("FAIL msb_word got=%b want=1011", po4m);
        end
        checks++;
        if (po4l !== 4'b1101) begin
            errors++;
            $display("FAIL lsb_word got=%b want=1101", po4l);
        end
        checks++;
        if (wd4m !== 1'b1 || wd4l !== 1'b1 || bc4m !== 3'd0 || bc4l !== 3'd0) begin
            errors++;
            $display("FAIL dir_done got wdm=%b wdl=%b bcm=%0d bcl=%0d want 1 1 0 0",
                     wd4m, wd4l, bc4m, bc4l);
        end
        step(1'b0, 1'b0);
        checks++;
        if (wd4m !== 1'b0 || wd4l !== 1'b0 || po4m !== 4'b1011 || po4l !== 4'b1101) begin
            errors++;
            $display("FAIL dir_pulse_fall got wdm=%b wdl=%b m=%b l=%b want 0 0 1011 1101",
                     wd4m, wd4l, po4m, po4l);
        end
    endtask

    task automatic test_hold();
        logic [7:0] byte_in;
        byte_in = 8'hA5;
        assert_reset();
        release_reset();
        for (int i = 7; i >= 0; i--) step(1'b1, byte_in[i]);
        for (int c = 0; c < 10; c++) begin
            step(1'b0, c[0]);
            checks++;
            if (po32 !== 32'hFFFF_FFA5 || bc32 !== 6'd8 || wd32 !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d] got po=%h bc=%0d wd=%b want po=ffffffa5 bc=8 wd=0",
                         c, po32, bc32, wd32);
            end
        end
    endtask

    task automatic test_continuous();
        assert_reset();
        release_reset();
        for (int k = 1; k <= 64; k++) begin
            step(1'b1, (k % 2 == 1));
            checks++;
            if (wd32 !== ((k == 32) || (k == 64))) begin
                errors++;
                $display("FAIL stream_done[%0d] got=%b want=%b", k, wd32, (k == 32) || (k == 64));
            end
            if (k == 32 || k == 64) begin
                checks++;
                if (po32 !== 32'hAAAA_AAAA || bc32 !== 6'd0) begin
                    errors++;
                    $display("FAIL stream_word[%0d] got po=%h bc=%0d want po=aaaaaaaa bc=0",
                             k, po32, bc32);
                end
            end
        end
        step(1'b0, 1'b0);
        checks++;
        if (wd32 !== 1'b0) begin
            errors++;
            $display("FAIL stream_fall got=%b want=0", wd32);
        end
    endtask

    task automatic test_mid_word_reset();
        int pulses;
        int pulse_at;
        pulses   = 0;
        pulse_at = -1;
        assert_reset();
        release_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom_range(0, 1)));
        assert_reset();
        checks++;
        if (bc32 !== 6'd0 || po32 !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL midword_reset got po=%h bc=%0d want po=ffffffff bc=0", po32, bc32);
        end
        release_reset();
        for (int k = 1; k <= 32; k++) begin
            step(1'b1, 1'b0);
            if (wd32 === 1'b1) begin
                pulses++;
                pulse_at = k;
            end
        end
        checks++;
        if (pulses != 1 || pulse_at != 32) begin
            errors++;
            $display("FAIL midword_pulses got count=%0d at=%0d want count=1 at=32", pulses, pulse_at);
        end
        checks++;
        if (po32 !== 32'h0) begin
            errors++;
            $display("FAIL midword_word got=%h want=00000000", po32);
        end
    endtask

    task automatic test_random();
        assert_reset();
        release_reset();
        for (int s = 0; s < 400; s++) begin
            if (s == 200) begin
                assert_reset();
                release_reset();
            end
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (act_word[d] !== exp_word(cfg_n[d], cfg_msb[d]) ||
                    act_cnt[d] !== 8'(exp_count(cfg_n[d])) ||
                    act_done[d] !== exp_done(cfg_n[d])) begin
                    errors++;
                    $display("FAIL random[%0d] dut%0d got w=%h c=%0d d=%b want w=%h c=%0d d=%b",
                             s, d, act_word[d], act_cnt[d], act_done[d],
                             exp_word(cfg_n[d], cfg_msb[d]), exp_count(cfg_n[d]),
                             exp_done(cfg_n[d]));
                end
            end
        end
    endtask

    initial begin
        n_rst        = 1'b1;
        shift_enable = 1'b0;
        serial_in    = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        release_reset();

        test_reset();
        test_direction();
        test_hold();
        test_continuous();
        test_mid_word_reset();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
